// File: rtl/mac_result_serializer.sv
// mac_result_serializer: LSB-first parallel-to-serial stage; MAC_SER_PARITY_EN appends an even-parity bit
module mac_result_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             R,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  input  logic             ser_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_last,
  output logic             busy
);
`ifdef MAC_SER_PARITY_EN
  localparam int N = WIDTH + 1;
`else
  localparam int N = WIDTH;
`endif
  localparam int CW = $clog2(WIDTH + 2);
  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;
  state_t state, next;
  logic [N-1:0] sr, word;
  logic [CW-1:0] cnt;
  logic last, load, xfer;
`ifdef MAC_SER_PARITY_EN
  assign word = {^load_data, load_data};
`else
  assign word = load_data;
`endif
  assign load = load_valid && load_ready;
  assign xfer = (state == SHIFT) && ser_ready;
  // state register
  always_ff @(posedge CLK)
    state <= R ? IDLE : next;
  // next-state: accept a word in IDLE, leave SHIFT after the final bit transfers
  always_comb
    next = (state == IDLE) ? (load ? SHIFT : IDLE) : ((xfer && last) ? IDLE : SHIFT);
  // shift register, bit counter and registered last flag
  always_ff @(posedge CLK)
    if (R) begin
      sr   <= '0;
      cnt  <= '0;
      last <= 1'b0;
    end else if (load) begin
      sr   <= word;
      cnt  <= '0;
      last <= 1'b0;
    end else if (xfer) begin
      sr   <= sr >> 1;
      cnt  <= cnt + 1'b1;
      last <= (cnt == CW'(N - 2));
    end
  // outputs decoded from registered state
  always_comb begin
    load_ready = (state == IDLE) && !R;
    ser_valid  = (state == SHIFT);
    busy       = (state == SHIFT);
    ser_out    = sr[0];
    ser_last   = last;
  end
endmodule

// File: tb/tb_mac_result_serializer.sv
// tb_mac_result_serializer: table vectors, corner sequences and random traffic against a bit-queue model
module tb_mac_result_serializer;
`ifdef MAC_SER_PARITY_EN
  localparam int NB = 9;
  localparam logic PE = 1'b1;
`else
  localparam int NB = 8;
  localparam logic PE = 1'b0;
`endif
  logic CLK = 0, R = 1, load_valid = 0, ser_ready = 0;
  logic [7:0] load_data = 0;
  logic load_ready, ser_out, ser_valid, ser_last, busy;
  int tests = 0, fails = 0, cyc = 0;
  logic mq[$];
  typedef struct packed {
    logic r, lv; logic [7:0] d; logic s;
    logic o, v, l, rd, b;
  } vec_t;
  vec_t tbl[$];

  mac_result_serializer #(.WIDTH(8)) dut (
    .CLK(CLK), .R(R), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .ser_ready(ser_ready), .ser_out(ser_out),
    .ser_valid(ser_valid), .ser_last(ser_last), .busy(busy)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic vec_t mk(logic r, lv, logic [7:0] d, logic s, logic o, v, l, rd, b);
    vec_t x;
    x.r = r; x.lv = lv; x.d = d; x.s = s; x.o = o; x.v = v; x.l = l; x.rd = rd; x.b = b;
    return x;
  endfunction

  task automatic step(input logic r, lv, input logic [7:0] d, input logic s, input logic use_v, input vec_t v,
                      output logic acc, output logic xb, output logic xv, output logic xl);
    logic e;
    R = r; load_valid = lv; load_data = d; ser_ready = s;
    #3;
    e = (mq.size() != 0);
    chk("model_valid", ser_valid, e);
    chk("model_busy", busy, e);
    chk("model_ready", load_ready, !e && !r);
    chk("model_out", ser_out, e ? mq[0] : 1'b0);
    chk("model_last", ser_last, e && mq.size() == 1);
    if (use_v) begin
      chk("tbl_out", ser_out, v.o);
      chk("tbl_valid", ser_valid, v.v);
      chk("tbl_last", ser_last, v.l);
      chk("tbl_ready", load_ready, v.rd);
      chk("tbl_busy", busy, v.b);
    end
    acc = !r && !e && lv;
    xv = !r && e && s;
    xb = e ? mq[0] : 1'b0;
    xl = e && mq.size() == 1;
    @(posedge CLK);
    if (r) mq.delete();
    else if (acc) begin
      for (int i = 0; i < 8; i++) mq.push_back(d[i]);
      if (PE) mq.push_back(^d);
    end else if (xv) void'(mq.pop_front());
    cyc++;
    #1;
  endtask

  task automatic frame(input logic [7:0] d, input logic [3:0] pat, output logic [8:0] bits);
    logic a, xb, xv, xl;
    int n;
    bits = 0; n = 0; a = 0;
    for (int i = 0; i < 20 && !a; i++) step(0, 1, d, 1, 0, '0, a, xb, xv, xl);
    chk("accept", a, 1);
    for (int i = 0; i < 80 && n < NB; i++) begin
      step(0, 0, 8'h00, pat[i % 4], 0, '0, a, xb, xv, xl);
      if (xv) begin
        bits[n] = xb;
        chk("last_pos", xl, n == NB - 1);
        n++;
      end
    end
    chk("frame_len", n, NB);
  endtask

  initial begin
    logic a, xb, xv, xl;
    logic [8:0] bits;
    int acc_cyc, last_cyc;
    R = 1;
    @(posedge CLK); #1;
    tbl.push_back(mk(1, 0, 8'h00, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 8'hA5, 1, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 8'h00, 1, 1, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 8'h00, 1, 0, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 8'h00, 1, 1, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 8'h00, 1, 0, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 8'h00, 1, 0, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 8'h00, 1, 1, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 8'h00, 1, 0, 1, 0, 0, 1));
`ifdef MAC_SER_PARITY_EN
    tbl.push_back(mk(0, 0, 8'h00, 1, 1, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 8'h00, 1, 0, 1, 1, 0, 1));
`else
    tbl.push_back(mk(0, 0, 8'h00, 1, 1, 1, 1, 0, 1));
`endif
    tbl.push_back(mk(0, 0, 8'h00, 1, 0, 0, 0, 1, 0));
    foreach (tbl[i]) step(tbl[i].r, tbl[i].lv, tbl[i].d, tbl[i].s, 1, tbl[i], a, xb, xv, xl);

    frame(8'h3C, 4'b1001, bits);
    chk("bp_3C", bits, {PE & 1'b0, 8'h3C});

    a = 0;
    for (int i = 0; i < 20 && !a; i++) step(0, 1, 8'hFF, 1, 0, '0, a, xb, xv, xl);
    chk("b2b_accept1", a, 1);
    a = 0; last_cyc = -100; acc_cyc = -1;
    for (int i = 0; i < 40 && !a; i++) begin
      step(0, 1, 8'h01, 1, 0, '0, a, xb, xv, xl);
      if (xv && xl) last_cyc = cyc - 1;
      if (a) acc_cyc = cyc - 1;
    end
    chk("b2b_gap", acc_cyc - last_cyc, 1);
    bits = 0;
    for (int n = 0, i = 0; i < 40 && n < NB; i++) begin
      step(0, 0, 8'h00, 1, 0, '0, a, xb, xv, xl);
      if (xv) begin bits[n] = xb; n++; end
    end
    chk("b2b_01", bits, {PE & 1'b1, 8'h01});

    a = 0;
    for (int i = 0; i < 20 && !a; i++) step(0, 1, 8'hF0, 1, 0, '0, a, xb, xv, xl);
    for (int i = 0; i < 3; i++) step(0, 0, 8'h00, 1, 0, '0, a, xb, xv, xl);
    step(1, 1, 8'h55, 1, 0, '0, a, xb, xv, xl);
    chk("rst_valid", ser_valid, 0);
    chk("rst_last", ser_last, 0);
    chk("rst_busy", busy, 0);
    R = 0; #1;
    chk("rst_ready", load_ready, 1);
    frame(8'h81, 4'b1111, bits);
    chk("after_rst_81", bits, {PE & 1'b0, 8'h81});

    frame(8'h07, 4'b1111, bits);
    chk("par_07", bits, {PE & 1'b1, 8'h07});
    frame(8'hA5, 4'b1011, bits);
    chk("par_A5", bits, {PE & 1'b0, 8'hA5});

    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 99) < 3, $urandom_range(0, 1), 8'($urandom), $urandom_range(0, 9) < 7,
           0, '0, a, xb, xv, xl);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
